// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for a 5-stage pipeline with
// branches resolved in ID and a multi-cycle mult/div unit.
// Optional build macro HAZARD_PERF_CNT_EN adds StallCycles/FlushCount
// performance counters (saturating, 32 bit).
//
// Mult/div FSM states
//   state | meaning
//   IDLE  | unit free, HI/LO readable
//   BUSY  | unit computing; Cnt counts down to the terminal count 0
module hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       ResetN,
    input  logic [4:0] RsID,
    input  logic [4:0] RtID,
    input  logic       UsesRsID,
    input  logic       UsesRtID,
    input  logic       IsBranchID,
    input  logic       BranchTakenID,
    input  logic       HiLoUseID,
    input  logic [4:0] WriteRegAddrEX,
    input  logic       RegWriteEX,
    input  logic       MemReadEX,
    input  logic       MdStartEX,
    input  logic [4:0] WriteRegAddrMEM,
    input  logic       RegWriteMEM,
    input  logic       MemReadMEM,
    output logic       PCWriteEnable,
    output logic       IFIDWriteEnable,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       MdBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic {IDLE, BUSY} mdState_t;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_LAT - 1);

    mdState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;

    logic matchEx, matchMem;
    logic loadUse, brHaz, mdHaz, stall;

    // Source-operand match against the EX and MEM destinations; $0 never matches.
    always_comb begin
        matchEx  = (WriteRegAddrEX != 5'd0) &&
                   ((UsesRsID && (RsID == WriteRegAddrEX)) ||
                    (UsesRtID && (RtID == WriteRegAddrEX)));
        matchMem = (WriteRegAddrMEM != 5'd0) &&
                   ((UsesRsID && (RsID == WriteRegAddrMEM)) ||
                    (UsesRtID && (RtID == WriteRegAddrMEM)));
    end

    // Hazard detection; a load feeding a branch stalls once in EX and again in MEM.
    always_comb begin
        loadUse = MemReadEX && RegWriteEX && matchEx;
        brHaz   = IsBranchID && ((RegWriteEX && matchEx) ||
                                 (MemReadMEM && RegWriteMEM && matchMem));
        mdHaz   = HiLoUseID && ((state == BUSY) || MdStartEX);
        stall   = loadUse || brHaz || mdHaz;
    end

    // Pipeline control outputs; reset purges both pipeline registers.
    always_comb begin
        PCWriteEnable   = 1'b1;
        IFIDWriteEnable = 1'b1;
        IFIDFlush       = 1'b0;
        IDEXFlush       = 1'b0;
        MdBusy          = 1'b0;
        if (!ResetN) begin
            PCWriteEnable   = 1'b0;
            IFIDWriteEnable = 1'b0;
            IFIDFlush       = 1'b1;
            IDEXFlush       = 1'b1;
        end else begin
            MdBusy = (state == BUSY);
            if (stall) begin
                PCWriteEnable   = 1'b0;
                IFIDWriteEnable = 1'b0;
                IDEXFlush       = 1'b1;
            end else if (BranchTakenID) begin
                IFIDFlush = 1'b1;
            end
        end
    end

    // Mult/div next state: load on start, count down, leave at terminal count.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (MdStartEX) begin
                    stateNext = BUSY;
                    cntNext   = CntLoad;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cntNext = cnt - 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Mult/div state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!ResetN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counters of stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk) begin
        if (!ResetN) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (stall && (StallCycles != 32'hFFFF_FFFF)) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (IFIDFlush && (FlushCount != 32'hFFFF_FFFF)) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the stall/flush inputs of the IF/ID and ID/EX pipeline registers and the PC write enable.
- Inspects the register fields and control bits travelling through the ID, EX and MEM stages.
- Detects load-use and branch-operand hazards (branches resolve in ID), and squashes wrong-path fetches on taken branches and jumps.
- Tracks the multi-cycle multiply/divide unit with a countdown FSM, stalling HI/LO consumers until the result is ready.

Parameters:
- MULDIV_LAT, 32, cycles the mult/div unit stays busy after a start; legal range 1..63.
- CNT_W, 6, width of the busy countdown; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  rising-edge clock
- ResetN  in  1  synchronous active-low reset
- RsID  in  5  rs field of instruction in ID
- RtID  in  5  rt field of instruction in ID
- UsesRsID  in  1  ID instruction reads rs
- UsesRtID  in  1  ID instruction reads rt
- IsBranchID  in  1  ID instruction is a conditional branch (compares in ID)
- BranchTakenID  in  1  branch/jump redirect resolved in ID this cycle
- HiLoUseID  in  1  ID instruction is mfhi/mflo/mult/div (needs idle mult/div unit)
- WriteRegAddrEX  in  5  destination register of EX instruction
- RegWriteEX  in  1  EX instruction writes a register
- MemReadEX  in  1  EX instruction is a load
- MdStartEX  in  1  EX instruction is mult/div (starts the unit this cycle)
- WriteRegAddrMEM  in  5  destination register of MEM instruction
- RegWriteMEM  in  1  MEM instruction writes a register
- MemReadMEM  in  1  MEM instruction is a load
- PCWriteEnable  out  1  PC may advance
- IFIDWriteEnable  out  1  IF/ID register may load
- IFIDFlush  out  1  clear IF/ID
- IDEXFlush  out  1  insert bubble into ID/EX
- MdBusy  out  1  mult/div unit busy (state BUSY)

Behaviour:
- Match helper: M(a) = (a != 0) && ((UsesRsID && RsID == a) || (UsesRtID && RtID == a)). Register 0 never matches.
- LoadUse = MemReadEX && RegWriteEX && M(WriteRegAddrEX).
- BrHaz = IsBranchID && ((RegWriteEX && M(WriteRegAddrEX)) || (MemReadMEM && RegWriteMEM && M(WriteRegAddrMEM))).
  - A load in EX feeding a branch gives 2 stall cycles naturally: EX match, then MEM match.
- MdHaz = HiLoUseID && (MdBusy || MdStartEX).
- Stall = LoadUse || BrHaz || MdHaz.
- Outputs are combinational from the current inputs and state; zero-cycle latency.
- While ResetN = 1:
  - Stall = 1: PCWriteEnable = 0, IFIDWriteEnable = 0, IDEXFlush = 1, IFIDFlush = 0.
  - Stall = 0 and BranchTakenID = 1: PCWriteEnable = 1, IFIDWriteEnable = 1, IFIDFlush = 1, IDEXFlush = 0.
  - Otherwise: PCWriteEnable = 1, IFIDWriteEnable = 1, both flushes 0.
- Stall has priority over BranchTakenID. A branch is not taken while its operands are pending; the redirect is acted on in the first non-stalled cycle.
- While ResetN = 0, regardless of other inputs: PCWriteEnable = 0, IFIDWriteEnable = 0, IFIDFlush = 1, IDEXFlush = 1, MdBusy = 0. This purges the pipeline registers, which have no reset of their own.
- Mult/div FSM:
  - States IDLE, BUSY; register Cnt[CNT_W-1:0].
  - Reset: IDLE, Cnt = 0.
  - IDLE with MdStartEX = 1: go to BUSY, Cnt = MULDIV_LAT - 1. A start in IDLE when MULDIV_LAT = 1 gives exactly one BUSY cycle.
  - BUSY with Cnt != 0: Cnt decrements by 1.
  - BUSY with Cnt == 0: return to IDLE.
  - MdBusy = (state == BUSY). BUSY lasts exactly MULDIV_LAT cycles.
  - MdStartEX while BUSY is ignored (no reload). The ID stall prevents it in legal flows.
  - Reset mid-BUSY: IDLE on the next edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs StallCycles[31:0] and FlushCount[31:0], both reset to 0 by ResetN.
  - StallCycles increments on every cycle with Stall = 1 and ResetN = 1.
  - FlushCount increments on every cycle with IFIDFlush = 1 and ResetN = 1.
  - Both saturate at 32'hFFFFFFFF.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: lw $8 in EX (MemReadEX = 1, RegWriteEX = 1, WriteRegAddrEX = 8); ID reads rs = 8 with UsesRsID = 1 -> one cycle of PCWriteEnable = 0, IFIDWriteEnable = 0, IDEXFlush = 1. Same case with RsID = 0 and WriteRegAddrEX = 0 -> no stall.
- Branch after load: beq reading $9 while lw $9 is in EX, then in MEM on the next cycle -> Stall for 2 consecutive cycles. With an ALU writer of $9 in EX instead -> exactly 1 stall cycle.
- Taken branch with no hazard: BranchTakenID = 1 -> IFIDFlush = 1, PCWriteEnable = 1 for 1 cycle. BranchTakenID = 1 together with BrHaz -> IFIDFlush = 0, stall wins.
- Mult/div with MULDIV_LAT = 4: MdStartEX pulse at cycle 0, then HiLoUseID = 1 held -> MdBusy high for cycles 1..4, Stall high for cycles 0..4, released at cycle 5. Repeat with MULDIV_LAT = 1 -> MdBusy for exactly 1 cycle.
- Reset mid-BUSY: ResetN = 0 at BUSY with Cnt = 2 -> during reset outputs are 0/0/1/1 and MdBusy = 0; after release, idle run values (1/1/0/0).
- HAZARD_PERF_CNT_EN defined: 3 stall cycles and 2 flush cycles -> StallCycles = 3, FlushCount = 2. Preload near max -> counters hold at 32'hFFFFFFFF.
